// File: rtl/ddr_guard_pkg.sv
// Shared types, response codes and the burst range check for the DDR read guard.
package ddr_guard_pkg;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      DRAIN = 2'd1,
      ERR   = 2'd2
   } guard_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Last byte of the burst is computed one bit wider so a wrap past the top of the address space is caught.
   function automatic logic range_bad(
      input logic [63:0] addr,
      input logic [7:0]  len,
      input logic [2:0]  size,
      input logic [63:0] max_addr,
      input logic [2:0]  max_size
   );
      logic [64:0] bytes;
      logic [64:0] last;
      bytes = ({57'd0, len} + 65'd1) << size;
      last  = {1'b0, addr} + bytes - 65'd1;
      return last[64] || (last > {1'b0, max_addr}) || (size > max_size);
   endfunction

endpackage

// File: rtl/ddr_ar_slice.sv
// One-deep registered valid/ready slice; holds its payload stable until taken downstream.
module ddr_ar_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         full;
   logic [W-1:0] data;

   assign in_ready  = !full || out_ready;
   assign out_valid = full;
   assign out_data  = data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
         data <= in_data;
      end else if (out_ready) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/ddr_rd_range_guard.sv
// DDR read-channel guard: forwards in-range reads, answers out-of-range reads locally with DECERR.
// state | meaning
// PASS  | normal forwarding, AR accepted, R passes through
// DRAIN | bad AR taken, waiting for slice and outstanding reads to empty
// ERR   | emitting the DECERR burst for the rejected read
module ddr_rd_range_guard
   import ddr_guard_pkg::*;
#(
   parameter int          ID_W      = 16,
   parameter int          ADDR_W    = 64,
   parameter int          DATA_W    = 512,
   parameter logic [63:0] MAX_ADDR  = 64'h3_FFFF_FFFF,
   parameter int          MAX_OUTST = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ID_W-1:0]      s_arid,
   input  logic [ADDR_W-1:0]    s_araddr,
   input  logic [7:0]           s_arlen,
   input  logic [2:0]           s_arsize,
   input  logic [1:0]           s_arburst,
   input  logic                 s_arvalid,
   output logic                 s_arready,
   output logic [ID_W-1:0]      s_rid,
   output logic [DATA_W-1:0]    s_rdata,
   output logic [1:0]           s_rresp,
   output logic                 s_rlast,
   output logic                 s_rvalid,
   input  logic                 s_rready,
   output logic [ID_W-1:0]      m_arid,
   output logic [ADDR_W-1:0]    m_araddr,
   output logic [7:0]           m_arlen,
   output logic [2:0]           m_arsize,
   output logic [1:0]           m_arburst,
   output logic                 m_arvalid,
   input  logic                 m_arready,
   input  logic [ID_W-1:0]      m_rid,
   input  logic [DATA_W-1:0]    m_rdata,
   input  logic [1:0]           m_rresp,
   input  logic                 m_rlast,
   input  logic                 m_rvalid,
   output logic                 m_rready,
   output logic [31:0]          err_cnt,
   output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt
);

   localparam int          OW        = $clog2(MAX_OUTST+1);
   localparam int          AR_W      = ID_W + ADDR_W + 8 + 3 + 2;
   localparam logic [2:0]  MAX_SIZE  = 3'($clog2(DATA_W/8));
   localparam logic [OW-1:0] OUTST_LIM = OW'(MAX_OUTST);

   guard_state_e    state, state_nxt;
   logic [ID_W-1:0] err_id;
   logic [7:0]      err_len;
   logic [7:0]      beat;
   logic            ar_bad, ar_hs, take_bad;
   logic            slice_in_ready, slice_full;
   logic            outst_inc, outst_dec;

   assign ar_bad   = range_bad(64'(s_araddr), s_arlen, s_arsize, MAX_ADDR, MAX_SIZE);
   assign ar_hs    = s_arvalid && s_arready;
   assign take_bad = (state == PASS) && ar_hs && ar_bad;

   ddr_ar_slice #(.W(AR_W)) u_ar_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (ar_hs && !ar_bad),
      .in_ready  (slice_in_ready),
      .in_data   ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
      .out_valid (slice_full),
      .out_ready (m_arready),
      .out_data  ({m_arid, m_araddr, m_arlen, m_arsize, m_arburst})
   );

   assign m_arvalid = slice_full;

   always_comb begin
      state_nxt = state;
      s_arready = 1'b0;
      m_rready  = s_rready;
      s_rvalid  = m_rvalid;
      s_rid     = m_rid;
      s_rdata   = m_rdata;
      s_rresp   = m_rresp;
      s_rlast   = m_rlast;
      case (state)
         PASS: begin
            s_arready = slice_in_ready && (outst_cnt < OUTST_LIM);
            if (s_arvalid && s_arready && ar_bad) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Earlier forwarded data must fully return before the error burst.
            if (!slice_full && (outst_cnt == '0)) state_nxt = ERR;
         end
         ERR: begin
            m_rready = 1'b0;
            s_rvalid = 1'b1;
            s_rid    = err_id;
            s_rdata  = '0;
            s_rresp  = RESP_DECERR;
            s_rlast  = (beat == err_len);
            if (s_rready && s_rlast) state_nxt = PASS;
         end
         default: state_nxt = PASS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= PASS;
         err_id  <= '0;
         err_len <= '0;
         beat    <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (take_bad) begin
            err_id  <= s_arid;
            err_len <= s_arlen;
            beat    <= '0;
            if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
         end else if ((state == ERR) && s_rready) begin
            beat <= beat + 8'd1;
         end
      end
   end

   assign outst_inc = m_arvalid && m_arready;
   assign outst_dec = m_rvalid && m_rready && m_rlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_cnt <= '0;
      end else if (outst_inc && !outst_dec) begin
         outst_cnt <= outst_cnt + OW'(1);
      end else if (outst_dec && !outst_inc) begin
         outst_cnt <= outst_cnt - OW'(1);
      end
   end

endmodule

// File: doc/ddr_rd_range_guard.md
# ddr_rd_range_guard

Read-channel guard between the nova_subsystem DDR AXI4 master and DDR slot 0 of sh_ddr. In-range reads are forwarded through a one-deep registered AR slice. R data passes straight through. Reads that fall outside DDR are terminated locally with a DECERR burst, and the block keeps saturating error and outstanding statistics.

## Interface
Parameters:
- ID_W, 16, AXI ID width
- ADDR_W, 64, address width
- DATA_W, 512, data width; bytes per beat = DATA_W/8
- MAX_ADDR, 64'h3_FFFF_FFFF, last valid byte address (16 GB)
- MAX_OUTST, 32, maximum forwarded reads outstanding

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous and active-low
- s_arid / s_araddr / s_arlen / s_arsize / s_arburst  in  ID_W / ADDR_W / 8 / 3 / 2  AR from subsystem
- s_arvalid  in  1; s_arready  out  1
- s_rid / s_rdata / s_rresp / s_rlast / s_rvalid  out  ID_W / DATA_W / 2 / 1 / 1  R to subsystem
- s_rready  in  1
- m_arid / m_araddr / m_arlen / m_arsize / m_arburst / m_arvalid  out  same widths  AR to sh_ddr
- m_arready  in  1
- m_rid / m_rdata / m_rresp / m_rlast / m_rvalid  in  same widths  R from sh_ddr
- m_rready  out  1
- err_cnt  out  32  count of rejected reads, saturating
- outst_cnt  out  $clog2(MAX_OUTST+1)  current outstanding forwarded reads

## Operation
- Range check on s_araddr, computed in ADDR_W+1 bits: end = addr + ((arlen+1) << arsize) − 1.
- A read is an error if end > MAX_ADDR, if the carry bit is set, or if arsize > $clog2(DATA_W/8).
- FSM states: PASS, DRAIN, ERR.
- PASS:
  - s_arready = (!slice_full || m_arready) && outst_cnt < MAX_OUTST.
  - A good AR loads the slice.
  - A bad AR is accepted: it latches id and len, increments err_cnt, and moves to DRAIN.
- DRAIN:
  - s_arready = 0.
  - Leaves for ERR once slice_full == 0 and outst_cnt == 0, so the error never overtakes earlier data.
- ERR:
  - s_arready = 0, m_rready = 0.
  - Drives s_rvalid = 1, s_rid = latched id, s_rdata = 0, s_rresp = DECERR.
  - Emits len+1 beats, advancing on s_rready; s_rlast is asserted on the final beat.
  - The handshake of the final beat returns the FSM to PASS.
- R path in PASS and DRAIN: m_r* → s_r* combinational, and m_rready = s_rready.
- outst_cnt:
  - +1 on an m_ar handshake.
  - −1 on an m_r handshake with m_rlast.
  - Both in the same cycle: unchanged.
- err_cnt holds at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - State PASS; slice empty; all counters 0.
  - m_arvalid = 0, s_rvalid = 0 (when m_rvalid = 0).
  - s_arready = 1 (combinational from empty slice and zero count).
- AR latency: s_ar handshake in cycle N → m_arvalid = 1 in N+1.
- Slice behaviour:
  - m_ar* is stable while m_arvalid && !m_arready.
  - Back-to-back issue at full rate when m_arready = 1.
- R latency: 0 cycles in PASS and DRAIN.
- Error response timing:
  - Bad AR accepted in N with nothing outstanding → DRAIN in N+1 → ERR in N+2.
  - First DECERR beat is valid in N+2.
- Once asserted, s_rvalid stays high with stable payload until s_rready.
- rst_n asserted mid-burst: the burst is abandoned and all state returns to reset values immediately; no remaining beats are emitted.

## Structure
- ddr_guard_pkg holds:
  - the state enum guard_state_e {PASS, DRAIN, ERR};
  - RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11;
  - the range-check function.
- One sub-module, ddr_ar_slice: parameterised one-deep AR register slice with valid/ready.
- FSM, counters and R mux stay in the top.

## Test plan
- Single in-range read, araddr=0x1000, arlen=3, arsize=6: m_arvalid 1 cycle after the handshake; 4 R beats pass through with OKAY; outst_cnt goes 0→1→0.
- Out-of-range read, araddr=0x4_0000_0000, arlen=1, id=0x2A, nothing outstanding: no m_arvalid; 2 beats on s_r with rid=0x2A, DECERR, rdata=0, rlast on beat 2; err_cnt=1.
- Boundary straddle, araddr=0x3_FFFF_FFC0, arlen=1, arsize=6: rejected with DECERR ×2. The same read with arlen=0 is forwarded.
- Ordering: two good reads outstanding, then a bad read: DECERR is not emitted until both good rlasts are seen; s_arready stays 0 throughout DRAIN and ERR.
- Back-pressure and limits:
  - m_arready=0 for 5 cycles: m_ar* stable.
  - MAX_OUTST reads issued without R: s_arready=0 until one rlast returns.
  - Simultaneous issue and rlast: count unchanged.
- Reset during ERR beat 2 of 4: s_rvalid=0, state PASS, s_arready=1 on release.
